mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's fetch stage (F) and memory stage (M).
- Arbitrates between the two requests and sequences each fixed-latency access with a wait-state counter.
- Drives stallF/stallM to the hazard logic so each stage holds while its access is pending.
- Sits between the datapath and the external memory model.

Parameters:
- AW, 32, address width
- DW, 32, data width
- WAIT, 2, memory access cycles per transaction; legal range 1..15

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ireqF  in  1  fetch request; held until ireadyF
- iaddrF  in  AW  fetch address
- irdataF  out  DW  fetched instruction; valid when ireadyF=1
- ireadyF  out  1  one-cycle completion pulse for fetch
- dreqM  in  1  data request (memread|memwrite); held until dreadyM
- dwriteM  in  1  1=store, 0=load; qualified by dreqM
- daddrM  in  AW  data address
- dwdataM  in  DW  store data
- drdataM  out  DW  load data; valid when dreadyM=1
- dreadyM  out  1  one-cycle completion pulse for data
- stallF  out  1  ireqF & ~ireadyF
- stallM  out  1  dreqM & ~dreadyM
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched store data
- mem_rdata  in  DW  memory read data; valid on the last busy cycle

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, owner=F, counter=0.
  - mem_en, mem_we, ireadyF, dreadyM = 0.
  - mem_addr, mem_wdata, irdataF, drdataM = 0.
  - stallF and stallM stay combinational from the requests.
- States:
  - IDLE: no access.
  - BUSY: access in flight; owner bit is F or D.
  - DONE: ready pulse cycle.
- Grant in IDLE, at the rising edge:
  - dreqM=1: grant D (priority to the older instruction).
  - else ireqF=1: grant F.
  - Grant latches address, write data (D only), and write flag (D only); counter=WAIT-1; go to BUSY.
- BUSY:
  - mem_en=1; mem_we=owner D & latched write.
  - mem_addr and mem_wdata are held stable.
  - Counter decrements each cycle.
  - On the edge where counter==0: capture mem_rdata into irdataF or drdataM (loads/fetches only; stores leave drdataM unchanged); go to DONE.
  - BUSY therefore lasts exactly WAIT cycles.
- DONE:
  - Owner's ready=1 for this cycle only; mem_en=0.
  - At the edge: if the other requester's req=1, grant it directly (BUSY, alternating fairness).
  - Otherwise go to IDLE.
  - The just-served requester is never re-granted from DONE: its req is still high in this cycle for the finishing transaction.
- Isolated access latency:
  - Request visible in cycle t, BUSY t+1..t+WAIT, ready in t+WAIT+1.
  - The stage advances on the edge ending t+WAIT+1.
- Simultaneous requests in IDLE: D served first, then F granted from DONE with no idle cycle between.
- Requests are not cancellable:
  - If ireqF drops mid-transaction (branch redirect), the access completes and ireadyF still pulses; the pipeline ignores it.
  - dreqM must not drop while stallM=1.
- Data held in irdataF/drdataM persists until overwritten by the next capture for that port.
- Reset mid-BUSY aborts immediately. mem_en deasserts asynchronously. No ready pulse is produced.

Decomposition:
- Package mem_arb_pkg:
  - State encoding: S_IDLE=2'b00, S_BUSY=2'b01, S_DONE=2'b10.
  - Owner encoding: OWN_F=1'b0, OWN_D=1'b1.
  - Counter width constant CW=4.
- Sub-module wait_ctr:
  - Loadable down-counter with load, load value, and zero flag.
  - Async active-low reset.

Test Plan:
- WAIT=2, ireqF=1, iaddrF=0x00000040, memory returns 0x8C020004:
  - mem_en high 2 cycles with mem_addr=0x40.
  - ireadyF=1 with irdataF=0x8C020004 in cycle t+3; stallF=1 in t..t+2.
- ireqF and dreqM (load, addr 0x100 -> 0xDEADBEEF) asserted together in the same cycle:
  - D served first; dreadyM at t+3 with drdataM=0xDEADBEEF.
  - F BUSY at t+4..t+5, ireadyF at t+6.
- Store dwriteM=1, daddrM=0x200, dwdataM=0x12345678:
  - mem_we=1 for exactly WAIT cycles with stable addr/data; dreadyM pulses once.
  - drdataM unchanged.
- Back-to-back fetches (ireqF high continuously, address changes after each ireadyF):
  - Exactly one IDLE cycle between transactions.
  - No double grant of the same request.
- reset=0 asserted asynchronously mid-BUSY:
  - mem_en, mem_we, ireadyF, dreadyM drop without a clock edge; state=IDLE.
  - After release, a held ireqF is re-granted normally.
- WAIT=1: single busy cycle, ready at t+2; alternating F/D requests show direct DONE->BUSY hand-off.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// State, owner encodings and the wait-counter width.
package mem_arb_pkg;

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_wait_ctr.sv
// Loadable down-counter that times each fixed-latency memory access.
// Saturates at zero; zero flag marks the last busy cycle.
module wait_ctr
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch (F) and data (M) stages.
// Data side wins in IDLE; DONE hands off directly to the other requester.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireqF,
    input  logic [AW-1:0] iaddrF,
    output logic [DW-1:0] irdataF,
    output logic          ireadyF,
    input  logic          dreqM,
    input  logic          dwriteM,
    input  logic [AW-1:0] daddrM,
    input  logic [DW-1:0] dwdataM,
    output logic [DW-1:0] drdataM,
    output logic          dreadyM,
    output logic          stallF,
    output logic          stallM,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [CW-1:0] LOADV = CW'(WAIT - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          gnt_d, gnt_f;
    logic          load;
    logic          zero;

    wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst_n    (reset),
        .load     (load),
        .dec      (state_q == S_BUSY),
        .load_val (LOADV),
        .zero     (zero)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        gnt_d    = 1'b0;
        gnt_f    = 1'b0;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dreqM) begin
                    gnt_d = 1'b1;
                end else if (ireqF) begin
                    gnt_f = 1'b1;
                end
            end
            S_BUSY: begin
                if (zero) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_F) begin
                        irdata_d = mem_rdata;
                    end else if (!we_q) begin
                        drdata_d = mem_rdata;
                    end
                end
            end
            S_DONE: begin
                // The finishing requester still holds req here; never re-grant it.
                state_d = S_IDLE;
                if (owner_q == OWN_F && dreqM) begin
                    gnt_d = 1'b1;
                end else if (owner_q == OWN_D && ireqF) begin
                    gnt_f = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (gnt_d) begin
            state_d = S_BUSY;
            owner_d = OWN_D;
            we_d    = dwriteM;
            addr_d  = daddrM;
            wdata_d = dwdataM;
            load    = 1'b1;
        end else if (gnt_f) begin
            state_d = S_BUSY;
            owner_d = OWN_F;
            we_d    = 1'b0;
            addr_d  = iaddrF;
            load    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_F;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign mem_en    = (state_q == S_BUSY);
    assign mem_we    = mem_en && (owner_q == OWN_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign irdataF   = irdata_q;
    assign drdataM   = drdata_q;
    assign ireadyF   = (state_q == S_DONE) && (owner_q == OWN_F);
    assign dreadyM   = (state_q == S_DONE) && (owner_q == OWN_D);
    assign stallF    = ireqF && !ireadyF;
    assign stallM    = dreqM && !dreadyM;

endmodule
